instr_fetch_unit: RTL and testbench

//  Fetch stage upstream of ControlUnit. Holds the PC, issues word fetches to instruction memory over a

---
 rtl/instr_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, keeps at most one imem request in flight, buffers one
// early response in a skid register, and presents {pc, instr, opcode} to decode.
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic [6:0]      if_opcode
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_DROP = 3'd3;
  localparam logic [2:0] ST_SKID = 3'd4;

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0] out_instr_q, out_instr_d;

  logic out_free;
  logic req_pending_next;

  // The output slot can take new data if it is empty or being consumed this cycle.
  assign out_free = !out_valid_q || !stall;

  // A request remains outstanding past this edge if its response has not shown up yet.
  assign req_pending_next = ((state_q == ST_WAIT) && !imem_rsp_valid) ||
                            ((state_q == ST_REQ)  &&  imem_req_ready) ||
                            ((state_q == ST_DROP) && !imem_rsp_valid);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    skid_pc_d     = skid_pc_q;
    skid_instr_d  = skid_instr_q;
    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    out_instr_d   = out_instr_q;

    if (out_valid_q && !stall) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (imem_req_ready) begin
          inflight_pc_d = pc_q;
          pc_d          = pc_q + PC_STEP;
          state_d       = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          if (out_free) begin
            out_valid_d = 1'b1;
            out_pc_d    = inflight_pc_q;
            out_instr_d = imem_rsp_data;
            state_d     = ST_REQ;
          end else begin
            skid_pc_d    = inflight_pc_q;
            skid_instr_d = imem_rsp_data;
            state_d      = ST_SKID;
          end
        end
      end
      ST_SKID: begin
        if (!stall) begin
          out_valid_d = 1'b1;
          out_pc_d    = skid_pc_q;
          out_instr_d = skid_instr_q;
          state_d     = ST_REQ;
        end
      end
      ST_DROP: begin
        if (imem_rsp_valid) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Redirect flushes the output and skid; an in-flight response is discarded in DROP.
    if (redirect_valid) begin
      out_valid_d = 1'b0;
      pc_d        = redirect_pc & ALIGN_MASK;
      state_d     = req_pending_next ? ST_DROP : ST_REQ;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
    end
  end

  // NOTE: payload registers are only read when the FSM marks them live, so they carry no reset.
  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
    skid_pc_q     <= skid_pc_d;
    skid_instr_q  <= skid_instr_d;
  end

  assign imem_req_valid = (state_q == ST_REQ);
  assign imem_req_addr  = pc_q;
  assign if_valid       = out_valid_q;
  assign if_pc          = out_pc_q;
  assign if_instr       = out_instr_q;
  assign if_opcode      = out_instr_q[6:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized bench for instr_fetch_unit: an imem responder plus an
// in-order instruction-stream model (expected next PC, redirect retargets it).
module tb_instr_fetch_unit;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [6:0]  if_opcode;

  instr_fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_opcode      (if_opcode)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Stimulus knobs applied at the next negedge.
  logic        nx_rst_n = 1'b0;
  logic        nx_redirect = 1'b0;
  logic        nx_stall = 1'b0;
  logic [31:0] nx_redirect_pc = '0;
  int          rdy_mode  = 0;   // 0: ready high, 1: ready low, 2: random
  int          rsp_delay = 1;   // 0: random 1..4 cycles

  // Instruction memory responder state.
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          delay_left = 0;

  // Observations and reference model.
  bit          hs_now = 1'b0;
  logic [31:0] hs_addr = '0;
  logic [31:0] hs_q[$];
  logic [31:0] cons_q[$];
  logic [31:0] exp_pc = RESET_PC;
  bit          hold_prev = 1'b0;
  bit          redir_prev = 1'b0;
  bit          rst_prev = 1'b0;
  logic [31:0] held_pc = '0;
  logic [31:0] held_instr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a | 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_seen(input string tag, input bit got);
    total++;
    assert (got) else begin
      bad++;
      $error("FAIL %s: event not seen within cycle budget", tag);
    end
  endtask

  // Sample one cycle just before its rising edge and advance the model.
  task automatic observe();
    logic [31:0] ew;
    hs_now = 1'b0;
    if (!rst_n) begin
      exp_pc     = RESET_PC;
      pend       = 1'b0;
      hold_prev  = 1'b0;
      redir_prev = 1'b0;
      rst_prev   = 1'b1;
      return;
    end
    if (rst_prev) begin
      chk("reset_if_valid", 32'(if_valid), 32'd0);
      chk("reset_if_pc", if_pc, 32'd0);
      chk("reset_if_instr", if_instr, 32'd0);
      chk("reset_req_valid", 32'(imem_req_valid), 32'd0);
      rst_prev = 1'b0;
    end
    if (redir_prev) chk("flush_if_valid", 32'(if_valid), 32'd0);
    if (hold_prev) begin
      chk("hold_if_valid", 32'(if_valid), 32'd1);
      chk("hold_if_pc", if_pc, held_pc);
      chk("hold_if_instr", if_instr, held_instr);
    end
    if (if_valid && !stall) begin
      ew = mem_word(exp_pc);
      chk("stream_pc", if_pc, exp_pc);
      chk("stream_instr", if_instr, ew);
      chk("stream_opcode", 32'(if_opcode), 32'(ew[6:0]));
      cons_q.push_back(if_pc);
      exp_pc = exp_pc + 32'd4;
    end
    if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
    hold_prev  = if_valid && stall && !redirect_valid;
    held_pc    = if_pc;
    held_instr = if_instr;
    redir_prev = redirect_valid;
    if (imem_req_valid && imem_req_ready) begin
      chk("one_outstanding", 32'(pend), 32'd0);
      pend       = 1'b1;
      pend_addr  = imem_req_addr;
      delay_left = (rsp_delay == 0) ? int'($urandom_range(1, 4)) : rsp_delay;
      hs_now     = 1'b1;
      hs_addr    = imem_req_addr;
      hs_q.push_back(imem_req_addr);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    rst_n          = nx_rst_n;
    redirect_valid = nx_redirect;
    redirect_pc    = nx_redirect_pc;
    stall          = nx_stall;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (pend) begin
      if (delay_left <= 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
        pend           = 1'b0;
      end else begin
        delay_left--;
      end
    end
    case (rdy_mode)
      0:       imem_req_ready = 1'b1;
      1:       imem_req_ready = 1'b0;
      default: imem_req_ready = ($urandom_range(0, 2) != 0);
    endcase
    #4;
    observe();
  endtask

  task automatic do_reset();
    nx_rst_n    = 1'b0;
    nx_redirect = 1'b0;
    nx_stall    = 1'b0;
    cycle();
    cycle();
    nx_rst_n = 1'b1;
    hs_q.delete();
    cons_q.delete();
  endtask

  // what: 0 handshake, 1 response, 2 if_valid
  task automatic wait_for(input string tag, input int what, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      cycle();
      case (what)
        0:       got = hs_now;
        1:       got = imem_rsp_valid;
        default: got = if_valid;
      endcase
    end
    expect_seen(tag, got);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n0;
    int idle;
    bit got;
    logic [31:0] wrap_exp [3];
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;

    // 1: basic sequential fetch, 1-cycle memory.
    rdy_mode = 0; rsp_delay = 1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t1_first_valid_timing", 32'(if_valid), 32'(i == 3));
      if (i == 1) chk("t1_first_req_addr", imem_req_addr, RESET_PC);
    end
    for (int i = 0; i < 12 && cons_q.size() < 3; i++) cycle();
    expect_seen("t1_three_instrs", cons_q.size() >= 3);
    if (cons_q.size() >= 3 && hs_q.size() >= 3) begin
      chk("t1_req0", hs_q[0], 32'h0); chk("t1_req1", hs_q[1], 32'h4); chk("t1_req2", hs_q[2], 32'h8);
      chk("t1_pc0", cons_q[0], 32'h0); chk("t1_pc1", cons_q[1], 32'h4); chk("t1_pc2", cons_q[2], 32'h8);
    end

    // 2: imem not ready for 3 cycles.
    rdy_mode = 1;
    do_reset();
    cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t2_req_held", 32'(imem_req_valid), 32'd1);
      chk("t2_addr_held", imem_req_addr, 32'h0);
    end
    chk("t2_no_handshake", 32'(hs_q.size()), 32'd0);
    rdy_mode = 0;
    cycle();
    chk("t2_one_handshake", 32'(hs_q.size()), 32'd1);
    cycle();
    chk("t2_wait_no_req", 32'(imem_req_valid), 32'd0);

    // 3: redirect while waiting for 0x8.
    rsp_delay = 3;
    do_reset();
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin cycle(); got = hs_now && (hs_addr == 32'h8); end
    expect_seen("t3_fetch_0x8", got);
    nx_redirect = 1'b1; nx_redirect_pc = 32'h100;
    cycle();
    nx_redirect = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      chk("t3_valid_low_in_drop", 32'(if_valid), 32'd0);
      got = hs_now;
    end
    expect_seen("t3_refetch", got);
    chk("t3_refetch_addr", hs_addr, 32'h100);
    wait_for("t3_target_arrives", 2, 20);
    chk("t3_target_pc", if_pc, 32'h100);

    // 4: stall across a response, skid capture and release.
    rsp_delay = 2;
    wait_for("t4_sync_rsp", 1, 20);
    nx_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i == 0) chk("t4_output_valid", 32'(if_valid), 32'd1);
      if (i >= 3) chk("t4_no_req_in_skid", 32'(imem_req_valid), 32'd0);
    end
    nx_stall = 1'b0;
    n0 = cons_q.size();
    for (int i = 0; i < 20 && cons_q.size() < n0 + 3; i++) cycle();
    expect_seen("t4_stream_resumes", cons_q.size() >= n0 + 3);

    // 5: redirect, stall and response in the same cycle.
    wait_for("t5_sync_rsp", 1, 20);
    nx_stall = 1'b1;
    cycle();
    cycle();
    nx_redirect = 1'b1; nx_redirect_pc = 32'h203;
    cycle();
    chk("t5_rsp_coincides", 32'(imem_rsp_valid), 32'd1);
    nx_redirect = 1'b0; nx_stall = 1'b0;
    cycle();
    chk("t5_flushed", 32'(if_valid), 32'd0);
    chk("t5_req_no_drop", 32'(imem_req_valid), 32'd1);
    chk("t5_req_addr", imem_req_addr, 32'h200);
    wait_for("t5_target_arrives", 2, 20);
    chk("t5_target_pc", if_pc, 32'h200);

    // 6: reset mid-WAIT, then fetch across the address wrap.
    rsp_delay = 3;
    wait_for("t6_sync_hs", 0, 20);
    nx_rst_n = 1'b0;
    cycle();
    nx_rst_n = 1'b1;
    hs_q.delete();
    cons_q.delete();
    wait_for("t6_first_hs", 0, 20);
    chk("t6_reset_addr", hs_addr, RESET_PC);
    nx_redirect = 1'b1; nx_redirect_pc = 32'hFFFF_FFF8;
    cycle();
    nx_redirect = 1'b0;
    rsp_delay = 1;
    wrap_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    for (int k = 0; k < 3; k++) begin
      wait_for("t6_wrap_hs", 0, 20);
      chk("t6_wrap_addr", hs_addr, wrap_exp[k]);
    end
    for (int i = 0; i < 20 && cons_q.size() < 3; i++) cycle();
    expect_seen("t6_wrap_instrs", cons_q.size() >= 3);
    if (cons_q.size() >= 3) begin
      for (int k = 0; k < 3; k++) chk("t6_wrap_pc", cons_q[k], wrap_exp[k]);
    end

    // Random traffic against the stream model.
    rdy_mode = 2; rsp_delay = 0; idle = 0;
    for (int i = 0; i < 1500; i++) begin
      nx_stall    = ($urandom_range(0, 3) == 0);
      nx_redirect = ($urandom_range(0, 19) == 0);
      nx_redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : 32'($urandom_range(0, 32'h3FF));
      cycle();
      idle = (if_valid || redirect_valid) ? 0 : idle + 1;
      if (idle > 30) begin
        expect_seen("rand_progress", 1'b0);
        idle = 0;
      end
    end
    nx_stall = 1'b0; nx_redirect = 1'b0;
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
